// File: rtl/decode_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_reg
// Purpose  : Registered decode stage. Reads register operands, owns the
//            architectural register file and carries branch-prediction info
//            into an ID/EX register with a valid/ready handshake. It also
//            inserts load-use bubbles, honours a flush from the branch
//            resolver, and counts bubbles with a saturating counter.
// Options  : DECODE_WB_BYPASS_EN - when defined, a same-cycle writeback to a
//            source register is forwarded into the operand being loaded.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage_reg #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int RID_W = $clog2(NREG),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  // IF/ID side
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [31:0]      instruction,
  input  logic [XLEN-1:0]  pc,
  input  logic             bp_taken_in,
  input  logic [XLEN-1:0]  bp_target_in,
  // Writeback port
  input  logic             write_en,
  input  logic [RID_W-1:0] write_id,
  input  logic [XLEN-1:0]  write_data,
  // Execute side
  input  logic             flush_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [31:0]      instr_out,
  output logic [XLEN-1:0]  pc_out,
  output logic [RID_W-1:0] rs1_id_out,
  output logic [RID_W-1:0] rs2_id_out,
  output logic [RID_W-1:0] rd_id_out,
  output logic [XLEN-1:0]  read_data1,
  output logic [XLEN-1:0]  read_data2,
  output logic             bp_taken_out,
  output logic [XLEN-1:0]  bp_target_out,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  // Architectural register file; entry 0 is never written so it reads as 0.
  logic [XLEN-1:0] regs [NREG];

  // Register indices of the presented instruction (low RID_W bits of fields).
  logic [RID_W-1:0] rs1;
  logic [RID_W-1:0] rs2;
  logic [RID_W-1:0] rd;

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  logic is_load;
  logic hazard;
  logic advance;
  logic load_payload;
  logic insert_bubble;

  assign rs1 = instruction[15 +: RID_W];
  assign rs2 = instruction[20 +: RID_W];
  assign rd  = instruction[7  +: RID_W];

  // Operand read, optionally forwarding a same-cycle writeback.
  always_comb begin
    op1 = regs[rs1];
    op2 = regs[rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (write_en && (write_id != '0) && (write_id == rs1)) op1 = write_data;
    if (write_en && (write_id != '0) && (write_id == rs2)) op2 = write_data;
`endif
  end

  // Handshake and load-use hazard detection against the entry in ID/EX.
  assign is_load = (instr_out[6:0] == OPC_LOAD);
  assign hazard  = valid_out & is_load & (rd_id_out != '0) & valid_in &
                   ((rd_id_out == rs1) | (rd_id_out == rs2));
  assign advance = ~valid_out | ready_in;
  assign ready_out = flush_in | (advance & ~hazard);

  // Flush outranks everything; a bubble outranks loading.
  assign insert_bubble = ~flush_in & advance & hazard;
  assign load_payload  = ~flush_in & advance & ~hazard & valid_in;

  // Register file write: independent of stall and flush, index 0 ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (write_en && (write_id != '0)) begin
      regs[write_id] <= write_data;
    end
  end

  // ID/EX valid bit: set only when a new instruction is loaded, held on stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out <= 1'b0;
    end else if (flush_in || advance) begin
      valid_out <= load_payload;
    end
  end

  // ID/EX payload: captured on accept; operands sampled at load time only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_out     <= '0;
      pc_out        <= '0;
      rs1_id_out    <= '0;
      rs2_id_out    <= '0;
      rd_id_out     <= '0;
      read_data1    <= '0;
      read_data2    <= '0;
      bp_taken_out  <= 1'b0;
      bp_target_out <= '0;
    end else if (load_payload) begin
      instr_out     <= instruction;
      pc_out        <= pc;
      rs1_id_out    <= rs1;
      rs2_id_out    <= rs2;
      rd_id_out     <= rd;
      read_data1    <= op1;
      read_data2    <= op2;
      bp_taken_out  <= bp_taken_in;
      bp_target_out <= bp_target_in;
    end
  end

  // Saturating count of load-use bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_cnt <= '0;
    end else if (insert_bubble && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage_reg
// Purpose  : Directed self-checking bench for decode_stage_reg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage_reg;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int RID_W = 5;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             valid_in;
  logic             ready_out;
  logic [31:0]      instruction;
  logic [XLEN-1:0]  pc;
  logic             bp_taken_in;
  logic [XLEN-1:0]  bp_target_in;
  logic             write_en;
  logic [RID_W-1:0] write_id;
  logic [XLEN-1:0]  write_data;
  logic             flush_in;
  logic             ready_in;
  logic             valid_out;
  logic [31:0]      instr_out;
  logic [XLEN-1:0]  pc_out;
  logic [RID_W-1:0] rs1_id_out;
  logic [RID_W-1:0] rs2_id_out;
  logic [RID_W-1:0] rd_id_out;
  logic [XLEN-1:0]  read_data1;
  logic [XLEN-1:0]  read_data2;
  logic             bp_taken_out;
  logic [XLEN-1:0]  bp_target_out;
  logic [CNT_W-1:0] bubble_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  decode_stage_reg #(
    .XLEN (XLEN),
    .NREG (NREG),
    .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .instruction  (instruction),
    .pc           (pc),
    .bp_taken_in  (bp_taken_in),
    .bp_target_in (bp_target_in),
    .write_en     (write_en),
    .write_id     (write_id),
    .write_data   (write_data),
    .flush_in     (flush_in),
    .ready_in     (ready_in),
    .valid_out    (valid_out),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .rs1_id_out   (rs1_id_out),
    .rs2_id_out   (rs2_id_out),
    .rd_id_out    (rd_id_out),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .bp_taken_out (bp_taken_out),
    .bp_target_out(bp_target_out),
    .bubble_cnt   (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADD_X1_X5_X0 = 32'h000280B3;
  localparam logic [31:0] I_ADD_X2_X0_X0 = 32'h00000133;
  localparam logic [31:0] I_LW_X3_0_X4   = 32'h00022183;
  localparam logic [31:0] I_ADD_X7_X6_X3 = 32'h003303B3;
  localparam logic [31:0] I_ADD_X4_X0_X0 = 32'h00000233;
  localparam logic [31:0] I_ADD_X8_X7_X0 = 32'h00038433;

  logic [31:0] exp_bypass;

  initial begin
    reset_n = 1'b0;
    valid_in = 1'b0; instruction = '0; pc = '0;
    bp_taken_in = 1'b0; bp_target_in = '0;
    write_en = 1'b0; write_id = '0; write_data = '0;
    flush_in = 1'b0; ready_in = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_valid",  32'(valid_out), 32'd0);
    check("rst_bubble", 32'(bubble_cnt), 32'd0);
    check("rst_instr",  instr_out, 32'd0);
    check("rst_rd1",    read_data1, 32'd0);
    check("rst_pc",     pc_out, 32'd0);
    reset_n = 1'b1;

    // Write x5 = 0x1234, then issue add x1,x5,x0
    write_en = 1'b1; write_id = 5'd5; write_data = 32'h1234;
    tick();
    write_en = 1'b0;
    valid_in = 1'b1; instruction = I_ADD_X1_X5_X0; pc = 32'h100;
    bp_taken_in = 1'b1; bp_target_in = 32'h200;
    #1 check("add1_ready", 32'(ready_out), 32'd1);
    tick();
    check("add1_valid",  32'(valid_out), 32'd1);
    check("add1_rd1",    read_data1, 32'h1234);
    check("add1_rd2",    read_data2, 32'd0);
    check("add1_rdid",   32'(rd_id_out), 32'd1);
    check("add1_rs1id",  32'(rs1_id_out), 32'd5);
    check("add1_pc",     pc_out, 32'h100);
    check("add1_bpt",    32'(bp_taken_out), 32'd1);
    check("add1_bptgt",  bp_target_out, 32'h200);

    // Write to x0 is ignored
    valid_in = 1'b0; bp_taken_in = 1'b0; bp_target_in = '0;
    write_en = 1'b1; write_id = 5'd0; write_data = 32'hFFFF_FFFF;
    tick();
    check("idle_valid", 32'(valid_out), 32'd0);
    write_en = 1'b0;
    valid_in = 1'b1; instruction = I_ADD_X2_X0_X0; pc = 32'h104;
    tick();
    check("x0_valid", 32'(valid_out), 32'd1);
    check("x0_rd1",   read_data1, 32'd0);
    check("x0_rd2",   read_data2, 32'd0);
    check("x0_rdid",  32'(rd_id_out), 32'd2);

    // Load-use: lw x3 then add x7,x6,x3 -> exactly one bubble
    instruction = I_LW_X3_0_X4; pc = 32'h108;
    tick();
    check("lw_valid", 32'(valid_out), 32'd1);
    check("lw_instr", instr_out, I_LW_X3_0_X4);
    instruction = I_ADD_X7_X6_X3; pc = 32'h10C;
    #1 check("haz_ready", 32'(ready_out), 32'd0);
    tick();
    check("bub_valid",  32'(valid_out), 32'd0);
    check("bub_cnt",    32'(bubble_cnt), 32'd1);
    check("bub_ready",  32'(ready_out), 32'd1);
    tick();
    check("luse_valid", 32'(valid_out), 32'd1);
    check("luse_instr", instr_out, I_ADD_X7_X6_X3);
    check("luse_rdid",  32'(rd_id_out), 32'd7);
    check("luse_rs2id", 32'(rs2_id_out), 32'd3);
    check("luse_cnt",   32'(bubble_cnt), 32'd1);

    // EX stall for 4 cycles with a new instruction waiting
    ready_in = 1'b0;
    instruction = I_ADD_X2_X0_X0; pc = 32'h300;
    for (int i = 0; i < 4; i++) begin
      #1 check("stall_ready", 32'(ready_out), 32'd0);
      tick();
      check("stall_valid", 32'(valid_out), 32'd1);
      check("stall_instr", instr_out, I_ADD_X7_X6_X3);
      check("stall_pc",    pc_out, 32'h10C);
    end
    ready_in = 1'b1;
    #1 check("rel_ready", 32'(ready_out), 32'd1);
    tick();
    check("rel_valid", 32'(valid_out), 32'd1);
    check("rel_instr", instr_out, I_ADD_X2_X0_X0);
    check("rel_pc",    pc_out, 32'h300);

    // Flush with a valid entry and a presented instruction
    flush_in = 1'b1; ready_in = 1'b0;
    instruction = I_ADD_X4_X0_X0; pc = 32'h400;
    #1 check("flush_ready", 32'(ready_out), 32'd1);
    tick();
    flush_in = 1'b0; ready_in = 1'b1; valid_in = 1'b0;
    check("flush_valid", 32'(valid_out), 32'd0);
    tick();
    check("flush_gone", 32'(valid_out), 32'd0);
    check("flush_cnt",  32'(bubble_cnt), 32'd1);

    // Same-cycle WB to x7 while issuing add x8,x7,x0
`ifdef DECODE_WB_BYPASS_EN
    exp_bypass = 32'hABCD;
`else
    exp_bypass = 32'h0;
`endif
    write_en = 1'b1; write_id = 5'd7; write_data = 32'hABCD;
    valid_in = 1'b1; instruction = I_ADD_X8_X7_X0; pc = 32'h500;
    tick();
    write_en = 1'b0;
    check("wb_same_valid", 32'(valid_out), 32'd1);
    check("wb_same_rd1",   read_data1, exp_bypass);
    check("wb_same_rdid",  32'(rd_id_out), 32'd8);
    tick();
    check("wb_next_rd1", read_data1, 32'hABCD);

    // Asynchronous reset mid-operation
    check("pre_rst_valid", 32'(valid_out), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid",  32'(valid_out), 32'd0);
    check("arst_cnt",    32'(bubble_cnt), 32'd0);
    check("arst_rd1",    read_data1, 32'd0);
    tick();
    reset_n = 1'b1;
    valid_in = 1'b1; instruction = I_ADD_X8_X7_X0;
    tick();
    check("arst_rf_clr", read_data1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
